pbkdf2_iter: RTL and testbench

PBKDF2_ITER -- requirements
Module: pbkdf2_iter

---
 rtl/pbkdf2_pkg.sv | 29 ++
 rtl/pbkdf2_msg_fmt.sv | 32 +++
 rtl/pbkdf2_iter.sv | 167 ++++++++++++++++
 tb/tb_pbkdf2_iter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbkdf2_pkg.sv
// Shared definitions for the PBKDF2 iteration controller.
// Holds the FSM state encoding, the bus widths used on the HMAC side,
// and a helper that clamps a salt length to what the message buffer holds.
package pbkdf2_pkg;

    localparam int KEY_W          = 512;
    localparam int MSG_W          = 440;
    localparam int DIGEST_W       = 256;
    localparam int SALT_MAX_BYTES = 51;
    localparam int INT_W          = 32;
    localparam int SALT_W         = 8 * SALT_MAX_BYTES;
    localparam int LEN_W          = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Salt lengths above SALT_MAX_BYTES are treated as SALT_MAX_BYTES.
    function automatic logic [LEN_W-1:0] clamp_salt_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(SALT_MAX_BYTES)) begin
            return LEN_W'(SALT_MAX_BYTES);
        end
        return len;
    endfunction

endpackage

// File: rtl/pbkdf2_msg_fmt.sv
// First HMAC message builder for PBKDF2 (purely combinational).
// Produces U_1's message: salt || INT(i), left-aligned in MSG_W bits.
// Ports:
//   salt_i      salt, left-aligned (bytes at/after salt_len_i are ignored)
//   salt_len_i  salt length in bytes, already clamped to SALT_MAX_BYTES
//   blk_idx_i   PBKDF2 block index i, written big-endian after the salt
//   msg_o       left-aligned message, zero beyond the last valid byte
//   msg_len_o   message length in bytes (salt_len_i + 4)
module pbkdf2_msg_fmt
    import pbkdf2_pkg::*;
(
    input  logic [SALT_W-1:0] salt_i,
    input  logic [LEN_W-1:0]  salt_len_i,
    input  logic [INT_W-1:0]  blk_idx_i,
    output logic [MSG_W-1:0]  msg_o,
    output logic [LEN_W-1:0]  msg_len_o
);

    logic [SALT_W-1:0] salt_mask;
    logic [SALT_W-1:0] salt_kept;

    // Mask keeps the top 8*salt_len bits; a full-length salt shifts the
    // all-ones pattern out completely, leaving every byte kept.
    assign salt_mask = ~({SALT_W{1'b1}} >> (8 * salt_len_i));
    assign salt_kept = salt_i & salt_mask;

    // INT(i) starts at the byte right after the salt.
    assign msg_o     = {salt_kept, {INT_W{1'b0}}}
                     | ({blk_idx_i, {SALT_W{1'b0}}} >> (8 * salt_len_i));
    assign msg_len_o = salt_len_i + LEN_W'(4);

endmodule

// File: rtl/pbkdf2_iter.sv
// PBKDF2 iteration controller: computes one derived block
//   T_i = U_1 ^ U_2 ^ ... ^ U_c
// by issuing c requests to an external HMAC stage.
// Handshakes (job in, result out, HMAC request, HMAC result): a transfer
// happens on the rising clk_i edge where valid and ready are both high;
// a raised valid keeps its payload stable until that edge.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   key_i, salt_i           password / salt, left-aligned
//   salt_len_i              salt bytes (clamped to 51)
//   blk_idx_i, iter_i       block index i, iteration count c (0 acts as 1)
//   v_i / r_o               job handshake
//   dk_o, v_o / r_i         result T_i and its handshake
//   hmac_key_o, hmac_msg_o, hmac_msg_len_o, hmac_v_o / hmac_r_i
//                           request to the HMAC stage
//   hmac_prf_i, hmac_v_i / hmac_r_o
//                           digest returned by the HMAC stage
//   state_o                 current FSM state (debug)
module pbkdf2_iter
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [KEY_W-1:0]    key_i,
    input  logic [SALT_W-1:0]   salt_i,
    input  logic [LEN_W-1:0]    salt_len_i,
    input  logic [INT_W-1:0]    blk_idx_i,
    input  logic [ITER_W-1:0]   iter_i,
    input  logic                v_i,
    output logic                r_o,
    output logic [DIGEST_W-1:0] dk_o,
    output logic                v_o,
    input  logic                r_i,
    output logic [KEY_W-1:0]    hmac_key_o,
    output logic [MSG_W-1:0]    hmac_msg_o,
    output logic [LEN_W-1:0]    hmac_msg_len_o,
    output logic                hmac_v_o,
    input  logic                hmac_r_i,
    input  logic [DIGEST_W-1:0] hmac_prf_i,
    input  logic                hmac_v_i,
    output logic                hmac_r_o,
    output logic [1:0]          state_o
);

    state_e              state_q,    state_d;
    logic [KEY_W-1:0]    key_q,      key_d;
    logic [SALT_W-1:0]   salt_q,     salt_d;
    logic [LEN_W-1:0]    salt_len_q, salt_len_d;
    logic [INT_W-1:0]    blk_idx_q,  blk_idx_d;
    logic [ITER_W-1:0]   count_q,    count_d;
    logic [ITER_W-1:0]   cnt_q,      cnt_d;
    logic [DIGEST_W-1:0] acc_q,      acc_d;
    logic [MSG_W-1:0]    msg_q,      msg_d;
    logic [LEN_W-1:0]    msg_len_q,  msg_len_d;

    logic [MSG_W-1:0]    fmt_msg;
    logic [LEN_W-1:0]    fmt_len;
    logic                first_iter;

    pbkdf2_msg_fmt u_msg_fmt (
        .salt_i     (salt_q),
        .salt_len_i (salt_len_q),
        .blk_idx_i  (blk_idx_q),
        .msg_o      (fmt_msg),
        .msg_len_o  (fmt_len)
    );

    // The first request uses salt || INT(i); later ones feed back U_{k-1}.
    // cnt_q is zero in reset, which keeps the message buses at zero there.
    assign first_iter     = (cnt_q == ITER_W'(1));
    assign hmac_key_o     = key_q;
    assign hmac_msg_o     = first_iter ? fmt_msg : msg_q;
    assign hmac_msg_len_o = first_iter ? fmt_len : msg_len_q;
    assign dk_o           = acc_q;

    // Handshake outputs depend on the registered state only.
    assign r_o      = (state_q == ST_IDLE);
    assign hmac_v_o = (state_q == ST_SEND);
    assign hmac_r_o = (state_q == ST_WAIT);
    assign v_o      = (state_q == ST_DONE);
    assign state_o  = state_q;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        salt_d     = salt_q;
        salt_len_d = salt_len_q;
        blk_idx_d  = blk_idx_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        msg_d      = msg_q;
        msg_len_d  = msg_len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (v_i && r_o) begin
                    key_d      = key_i;
                    salt_d     = salt_i;
                    salt_len_d = clamp_salt_len(salt_len_i);
                    blk_idx_d  = blk_idx_i;
                    count_d    = (iter_i == '0) ? ITER_W'(1) : iter_i;
                    cnt_d      = ITER_W'(1);
                    acc_d      = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hmac_r_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hmac_v_i) begin
                    acc_d = acc_q ^ hmac_prf_i;
                    // Compare before incrementing so cnt never passes count
                    // and cannot wrap even at the largest count.
                    if (cnt_q == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d     = cnt_q + ITER_W'(1);
                        msg_d     = {hmac_prf_i, {(MSG_W-DIGEST_W){1'b0}}};
                        msg_len_d = LEN_W'(DIGEST_W / 8);
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                if (r_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            salt_q     <= '0;
            salt_len_q <= '0;
            blk_idx_q  <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            msg_q      <= '0;
            msg_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            salt_q     <= salt_d;
            salt_len_q <= salt_len_d;
            blk_idx_q  <= blk_idx_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            msg_q      <= msg_d;
            msg_len_q  <= msg_len_d;
        end
    end

endmodule

// File: tb/tb_pbkdf2_iter.sv
// Bench for pbkdf2_iter with a behavioural HMAC-SHA256 stage attached.
module tb_pbkdf2_iter;
    import pbkdf2_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [511:0]   key_i;
    logic [407:0]   salt_i;
    logic [5:0]     salt_len_i;
    logic [31:0]    blk_idx_i;
    logic [31:0]    iter_i;
    logic           v_i;
    logic           r_o;
    logic [255:0]   dk_o;
    logic           v_o;
    logic           r_i;
    logic [511:0]   hmac_key_o;
    logic [439:0]   hmac_msg_o;
    logic [5:0]     hmac_msg_len_o;
    logic           hmac_v_o;
    logic           hmac_r_i;
    logic [255:0]   hmac_prf_i;
    logic           hmac_v_i;
    logic           hmac_r_o;
    logic [1:0]     state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [255:0] exp_q[$];

    int hmac_lat   = 2;
    int hmac_stall = 0;
    int hs_cnt     = 0;
    logic [511:0] cap_key;
    logic [439:0] cap_msg;
    logic [5:0]   cap_len;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    pbkdf2_iter #(.ITER_W(32)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .key_i          (key_i),
        .salt_i         (salt_i),
        .salt_len_i     (salt_len_i),
        .blk_idx_i      (blk_idx_i),
        .iter_i         (iter_i),
        .v_i            (v_i),
        .r_o            (r_o),
        .dk_o           (dk_o),
        .v_o            (v_o),
        .r_i            (r_i),
        .hmac_key_o     (hmac_key_o),
        .hmac_msg_o     (hmac_msg_o),
        .hmac_msg_len_o (hmac_msg_len_o),
        .hmac_v_o       (hmac_v_o),
        .hmac_r_i       (hmac_r_i),
        .hmac_prf_i     (hmac_prf_i),
        .hmac_v_i       (hmac_v_i),
        .hmac_r_o       (hmac_r_o),
        .state_o        (state_o)
    );

    // ---------------- HMAC-SHA256 reference ----------------
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
    endfunction

    // Key is one full 64-byte block; message is at most 55 bytes, so the
    // inner and outer hashes each need exactly two compressions.
    function automatic logic [255:0] hmac(input logic [511:0] key, input logic [439:0] msg,
                                          input logic [5:0] len);
        logic [439:0] m;
        logic [511:0] blk;
        logic [255:0] ih;
        m = msg & ~({440{1'b1}} >> (8 * len));
        blk = {m, 72'b0};
        blk[511 - 8*len -: 8] = 8'h80;
        blk[63:0] = 64'((64 + len) * 8);
        ih = sha_blk(sha_blk(SHA_IV, key ^ {64{8'h36}}), blk);
        blk = {ih, 8'h80, 184'b0, 64'd768};
        return sha_blk(sha_blk(SHA_IV, key ^ {64{8'h5c}}), blk);
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- HMAC stage responder ----------------
    initial begin
        logic [439:0] snap_msg;
        logic [511:0] snap_key;
        logic [255:0] prf;
        hmac_r_i   = 1'b1;
        hmac_v_i   = 1'b0;
        hmac_prf_i = '0;
        forever begin
            @(negedge clk_i);
            if (!(rst_ni && hmac_v_o)) begin
                hmac_r_i = (hmac_stall == 0);
            end else begin
                if (!hmac_r_i) begin
                    snap_msg = hmac_msg_o;
                    snap_key = hmac_key_o;
                    repeat (hmac_stall) begin
                        @(negedge clk_i);
                        check_eq("send_hold_v", 512'(hmac_v_o), 512'(1));
                        check_eq("send_hold_msg", 512'(hmac_msg_o), 512'(snap_msg));
                        check_eq("send_hold_key", hmac_key_o, snap_key);
                    end
                    hmac_r_i = 1'b1;
                end
                cap_key = hmac_key_o;
                cap_msg = hmac_msg_o;
                cap_len = hmac_msg_len_o;
                hs_cnt++;
                prf = hmac(hmac_key_o, hmac_msg_o, hmac_msg_len_o);
                @(posedge clk_i); #1;
                hmac_r_i = (hmac_stall == 0);
                repeat (hmac_lat) begin
                    @(posedge clk_i); #1;
                end
                hmac_v_i   = 1'b1;
                hmac_prf_i = prf;
                @(posedge clk_i); #1;
                hmac_v_i   = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_job(input logic [511:0] key, input logic [407:0] salt, input logic [5:0] len,
                             input logic [31:0] idx, input logic [31:0] iter);
        int t;
        @(posedge clk_i); #1;
        key_i = key; salt_i = salt; salt_len_i = len; blk_idx_i = idx; iter_i = iter;
        v_i = 1'b1;
        t = 0;
        @(negedge clk_i);
        while (!r_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (!r_o) check_eq("accept_timeout", 512'(r_o), 512'(1));
        @(posedge clk_i); #1;
        v_i = 1'b0;
    endtask

    task automatic run_job(input logic [511:0] key, input logic [407:0] salt, input logic [5:0] len,
                           input logic [31:0] idx, input logic [31:0] iter, input logic [255:0] exp,
                           input int hold, output int cycles);
        logic [255:0] exp_dk;
        exp_q.push_back(exp);
        drive_job(key, salt, len, idx, iter);
        cycles = 0;
        @(negedge clk_i);
        while (!v_o && cycles < 20000) begin
            @(posedge clk_i);
            cycles++;
            @(negedge clk_i);
        end
        check_eq("result_valid", 512'(v_o), 512'(1));
        exp_dk = exp_q.pop_front();
        check_eq("dk", 512'(dk_o), 512'(exp_dk));
        repeat (hold) begin
            @(negedge clk_i);
            check_eq("hold_v_o", 512'(v_o), 512'(1));
            check_eq("hold_r_o", 512'(r_o), 512'(0));
            check_eq("hold_dk", 512'(dk_o), 512'(exp_dk));
        end
        r_i = 1'b1;
        @(posedge clk_i); #1;
        r_i = 1'b0;
        check_eq("after_done_v_o", 512'(v_o), 512'(0));
        check_eq("after_done_r_o", 512'(r_o), 512'(1));
    endtask

    // ---------------- directed scenarios ----------------
    localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    initial begin
        logic [63:0]  s_pw;
        logic [31:0]  s_salt;
        logic [511:0] key_pw;
        logic [407:0] salt_junk, salt_clean, salt_long;
        logic [439:0] exp_msg;
        int cyc, base, t, vo_seen;

        s_pw       = "password";
        s_salt     = "salt";
        key_pw     = {s_pw, 448'b0};
        salt_junk  = {s_salt, {47{8'hA5}}};
        salt_clean = {s_salt, 376'b0};
        for (int b = 0; b < 51; b++) salt_long[407 - 8*b -: 8] = 8'(8'h40 + b);

        rst_ni = 1'b0; v_i = 1'b0; r_i = 1'b0;
        key_i = '0; salt_i = '0; salt_len_i = '0; blk_idx_i = '0; iter_i = '0;

        // Reset values, before any clock edge.
        #2;
        check_eq("rst_r_o", 512'(r_o), 512'(1));
        check_eq("rst_v_o", 512'(v_o), 512'(0));
        check_eq("rst_hmac_v_o", 512'(hmac_v_o), 512'(0));
        check_eq("rst_hmac_r_o", 512'(hmac_r_o), 512'(0));
        check_eq("rst_dk", 512'(dk_o), 512'(0));
        check_eq("rst_key", hmac_key_o, 512'(0));
        check_eq("rst_msg", 512'(hmac_msg_o), 512'(0));
        check_eq("rst_msg_len", 512'(hmac_msg_len_o), 512'(0));
        check_eq("rst_state", 512'(state_o), 512'(ST_IDLE));
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // c=1, junk after the 4 salt bytes, result held 10 cycles.
        hmac_lat = 2; hmac_stall = 0; base = hs_cnt;
        run_job(key_pw, salt_junk, 6'd4, 32'd1, 32'd1, DK_C1, 10, cyc);
        check_eq("c1_hs", 512'(hs_cnt - base), 512'(1));
        check_eq("c1_msg", 512'(cap_msg), 512'({s_salt, 32'd1, 376'b0}));
        check_eq("c1_len", 512'(cap_len), 512'(8));
        check_eq("c1_key", cap_key, key_pw);
        check_eq("c1_cycles", 512'(cyc), 512'(4));

        // c=2 with a stalling HMAC stage.
        hmac_lat = 1; hmac_stall = 2; base = hs_cnt;
        run_job(key_pw, salt_clean, 6'd4, 32'd1, 32'd2, DK_C2, 0, cyc);
        check_eq("c2_hs", 512'(hs_cnt - base), 512'(2));
        check_eq("c2_msg2", 512'(cap_msg), 512'({DK_C1, 184'b0}));
        check_eq("c2_len2", 512'(cap_len), 512'(32));
        check_eq("c2_cycles", 512'(cyc), 512'(10));

        // c=0 behaves as c=1.
        hmac_lat = 0; hmac_stall = 0; base = hs_cnt;
        run_job(key_pw, salt_clean, 6'd4, 32'd1, 32'd0, DK_C1, 0, cyc);
        check_eq("c0_hs", 512'(hs_cnt - base), 512'(1));
        check_eq("c0_cycles", 512'(cyc), 512'(2));

        // c=4096.
        base = hs_cnt;
        run_job(key_pw, salt_clean, 6'd4, 32'd1, 32'd4096, DK_C4096, 0, cyc);
        check_eq("c4096_hs", 512'(hs_cnt - base), 512'(4096));
        check_eq("c4096_cycles", 512'(cyc), 512'(8192));

        // Oversized salt length clamps to 51 bytes.
        exp_msg = {salt_long, 32'h01020304};
        run_job(key_pw, salt_long, 6'd60, 32'h01020304, 32'd1, hmac(key_pw, exp_msg, 6'd55), 0, cyc);
        check_eq("clamp_int_bytes", 512'(cap_msg[31:0]), 512'(32'h01020304));
        check_eq("clamp_len", 512'(cap_len), 512'(55));
        check_eq("clamp_msg", 512'(cap_msg), 512'(exp_msg));

        // Reset while waiting on the HMAC stage; its late reply is dropped.
        hmac_lat = 15; base = hs_cnt;
        drive_job(key_pw, salt_clean, 6'd4, 32'd1, 32'd1);
        check_eq("abort_state_send", 512'(state_o), 512'(ST_SEND));
        t = 0;
        while (hs_cnt == base && t < 50) begin
            @(posedge clk_i); #1;
            t++;
        end
        check_eq("abort_hs", 512'(hs_cnt - base), 512'(1));
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("abort_state_wait", 512'(state_o), 512'(ST_WAIT));
        rst_ni = 1'b0;
        #1;
        check_eq("abort_async_state", 512'(state_o), 512'(ST_IDLE));
        check_eq("abort_async_r_o", 512'(r_o), 512'(1));
        check_eq("abort_async_hmac_r_o", 512'(hmac_r_o), 512'(0));
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        vo_seen = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (v_o) vo_seen++;
        end
        check_eq("abort_no_v_o", 512'(vo_seen), 512'(0));
        check_eq("abort_idle", 512'(state_o), 512'(ST_IDLE));
        check_eq("abort_dk_zero", 512'(dk_o), 512'(0));
        hmac_lat = 2;
        run_job(key_pw, salt_clean, 6'd4, 32'd1, 32'd1, DK_C1, 0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
